// File: rtl/wb_store_queue_pkg.sv
// Shared types and constants for the write-back store queue: size encodings,
// byte-count lookup, quadword granularity and the store-entry layout.
package wb_store_queue_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 32;
    localparam int SIZE_W   = 2;
    localparam int PTC_W    = 7;
    localparam int QW_SHIFT = 3;
    localparam int QW_W     = ADDR_W - QW_SHIFT;

    typedef enum logic [SIZE_W-1:0] {
        SZ_1B = 2'b00,
        SZ_2B = 2'b01,
        SZ_4B = 2'b10,
        SZ_8B = 2'b11
    } st_size_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
        logic [PTC_W-1:0]  ptcid;
    } st_entry_t;

    function automatic logic [ADDR_W-1:0] sz_bytes(input logic [SIZE_W-1:0] sz);
        case (st_size_e'(sz))
            SZ_1B:   return 32'd1;
            SZ_2B:   return 32'd2;
            SZ_4B:   return 32'd4;
            default: return 32'd8;
        endcase
    endfunction

endpackage

// File: rtl/wb_store_queue_overlap.sv
// Quadword-granular overlap test between one store and one read; any equality
// among the start/end quadwords of either access counts as a conflict.
module wsq_overlap
    import wb_store_queue_pkg::*;
(
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [SIZE_W-1:0] st_size,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [SIZE_W-1:0] rd_size,
    output logic              conflict
);

    logic [ADDR_W-1:0] st_end, rd_end;
    logic [QW_W-1:0]   qs, qe, rs, re;

    // last byte address; carry out of bit 31 is dropped on purpose
    assign st_end = st_addr + sz_bytes(st_size) - 32'd1;
    assign rd_end = rd_addr + sz_bytes(rd_size) - 32'd1;

    assign qs = st_addr[ADDR_W-1:QW_SHIFT];
    assign qe = st_end[ADDR_W-1:QW_SHIFT];
    assign rs = rd_addr[ADDR_W-1:QW_SHIFT];
    assign re = rd_end[ADDR_W-1:QW_SHIFT];

    assign conflict = (qs == rs) | (qs == re) | (qe == rs) | (qe == re);

endmodule

// File: rtl/wb_store_queue.sv
// Write-back store queue: FIFO of committed stores drained into the cache
// write-back queue, plus load-vs-pending-store forwarding stall detection.
module wb_store_queue
    import wb_store_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              st_valid,
    input  logic [DATA_W-1:0] st_data,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [SIZE_W-1:0] st_size,
    input  logic [PTC_W-1:0]  st_ptcid,
    output logic              st_full,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_memdata,
    output logic [ADDR_W-1:0] wb_memaddr,
    output logic [SIZE_W-1:0] wb_size,
    output logic [PTC_W-1:0]  wb_ptcid,
    input  logic              wbaq_isfull,
    input  logic              q1_valid,
    input  logic              q2_valid,
    input  logic [ADDR_W-1:0] q1_addr,
    input  logic [ADDR_W-1:0] q2_addr,
    input  logic [SIZE_W-1:0] q_size,
    output logic              fwd_stall,
    output logic              sq_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    st_entry_t [DEPTH-1:0] mem;
    logic [DEPTH-1:0]      vld;
    logic [PTR_W-1:0]      head, tail;
    logic [CNT_W-1:0]      count;
    logic                  push, pop;
    st_entry_t             st_in, head_e;

    assign st_full  = (count == CNT_W'(DEPTH));
    assign wb_valid = (count != '0);
    assign sq_empty = ~wb_valid & ~st_valid;
    assign push     = st_valid & ~st_full;
    assign pop      = wb_valid & ~wbaq_isfull;

    assign st_in  = '{data: st_data, addr: st_addr, size: st_size, ptcid: st_ptcid};
    assign head_e = wb_valid ? mem[head] : '0;

    assign wb_memdata = head_e.data;
    assign wb_memaddr = head_e.addr;
    assign wb_size    = head_e.size;
    assign wb_ptcid   = head_e.ptcid;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            if (push) begin
                tail      <= tail + PTR_W'(1);
                vld[tail] <= 1'b1;
            end
            if (pop) begin
                head      <= head + PTR_W'(1);
                vld[head] <= 1'b0;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // payload needs no reset: it is only observed through vld / count
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= st_in;
    end

    // compare slots 0..DEPTH-1 are queue entries, slot DEPTH is the incoming store
    logic [DEPTH:0][ADDR_W-1:0] cmp_addr;
    logic [DEPTH:0][SIZE_W-1:0] cmp_size;
    logic [DEPTH:0]             cmp_v;
    logic [1:0][ADDR_W-1:0]     rd_addr;
    logic [1:0]                 rd_v;
    logic [1:0][DEPTH:0]        hit;
    logic [1:0]                 port_hit;

    assign cmp_addr[DEPTH] = st_addr;
    assign cmp_size[DEPTH] = st_size;
    assign cmp_v           = {st_valid, vld};
    assign rd_addr         = {q2_addr, q1_addr};
    assign rd_v            = {q2_valid, q1_valid};

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign cmp_addr[i] = mem[i].addr;
        assign cmp_size[i] = mem[i].size;
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        for (genvar i = 0; i <= DEPTH; i++) begin : g_cmp
            wsq_overlap u_ovl (
                .st_addr  (cmp_addr[i]),
                .st_size  (cmp_size[i]),
                .rd_addr  (rd_addr[p]),
                .rd_size  (q_size),
                .conflict (hit[p][i])
            );
        end
        assign port_hit[p] = rd_v[p] & (|(hit[p] & cmp_v));
    end

    assign fwd_stall = |port_hit;

endmodule

// File: tb/tb_wb_store_queue.sv
// Bench for wb_store_queue: directed scenarios plus a randomized run checked
// against a queue-based reference model with byte-level overlap arithmetic.
module tb_wb_store_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        st_valid = 1'b0;
    logic [63:0] st_data = '0;
    logic [31:0] st_addr = '0;
    logic [1:0]  st_size = '0;
    logic [6:0]  st_ptcid = '0;
    logic        st_full;
    logic        wb_valid;
    logic [63:0] wb_memdata;
    logic [31:0] wb_memaddr;
    logic [1:0]  wb_size;
    logic [6:0]  wb_ptcid;
    logic        wbaq_isfull = 1'b0;
    logic        q1_valid = 1'b0, q2_valid = 1'b0;
    logic [31:0] q1_addr = '0, q2_addr = '0;
    logic [1:0]  q_size = '0;
    logic        fwd_stall;
    logic        sq_empty;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] d;
        logic [31:0] a;
        logic [1:0]  s;
        logic [6:0]  p;
    } ent_t;
    ent_t mdl[$];

    always #5 clk = ~clk;

    wb_store_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .clr(clr),
        .st_valid(st_valid), .st_data(st_data), .st_addr(st_addr),
        .st_size(st_size), .st_ptcid(st_ptcid), .st_full(st_full),
        .wb_valid(wb_valid), .wb_memdata(wb_memdata), .wb_memaddr(wb_memaddr),
        .wb_size(wb_size), .wb_ptcid(wb_ptcid), .wbaq_isfull(wbaq_isfull),
        .q1_valid(q1_valid), .q2_valid(q2_valid), .q1_addr(q1_addr),
        .q2_addr(q2_addr), .q_size(q_size), .fwd_stall(fwd_stall),
        .sq_empty(sq_empty)
    );

    // true when any byte of the store and any byte of the read share a quadword
    function automatic bit span_hit(input logic [31:0] a, input logic [1:0] as,
                                    input logic [31:0] r, input logic [1:0] rs);
        logic [31:0] x, y;
        for (int i = 0; i < (1 << as); i++)
            for (int j = 0; j < (1 << rs); j++) begin
                x = a + 32'(i);
                y = r + 32'(j);
                if ((x >> 3) == (y >> 3)) return 1'b1;
            end
        return 1'b0;
    endfunction

    function automatic bit mdl_stall();
        bit s = 1'b0;
        foreach (mdl[k]) begin
            if (q1_valid && span_hit(mdl[k].a, mdl[k].s, q1_addr, q_size)) s = 1'b1;
            if (q2_valid && span_hit(mdl[k].a, mdl[k].s, q2_addr, q_size)) s = 1'b1;
        end
        if (st_valid && q1_valid && span_hit(st_addr, st_size, q1_addr, q_size)) s = 1'b1;
        if (st_valid && q2_valid && span_hit(st_addr, st_size, q2_addr, q_size)) s = 1'b1;
        return s;
    endfunction

    // one clock: model follows the FIFO rules with the inputs held across posedge
    task automatic tick();
        ent_t e;
        bit   pu, po;
        e.d = st_data; e.a = st_addr; e.s = st_size; e.p = st_ptcid;
        pu = st_valid && (mdl.size() < DEPTH);
        po = (mdl.size() > 0) && !wbaq_isfull;
        @(posedge clk);
        if (clr) mdl.delete();
        else begin
            if (po) void'(mdl.pop_front());
            if (pu) mdl.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drive_st(input bit v, input logic [63:0] d, input logic [31:0] a,
                            input logic [1:0] s, input logic [6:0] p);
        st_valid = v; st_data = d; st_addr = a; st_size = s; st_ptcid = p;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        #1;
        clr = 1'b0;
        mdl.delete();
    endtask

    task automatic test_reset();
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
        checks++; if (wb_memdata !== 64'd0) begin errors++; $display("FAIL reset_wb_memdata got=%h exp=0", wb_memdata); end
        checks++; if (st_full !== 1'b0) begin errors++; $display("FAIL reset_st_full got=%b exp=0", st_full); end
        checks++; if (sq_empty !== 1'b1) begin errors++; $display("FAIL reset_sq_empty got=%b exp=1", sq_empty); end
        checks++; if (fwd_stall !== 1'b0) begin errors++; $display("FAIL reset_fwd_stall got=%b exp=0", fwd_stall); end
        st_valid = 1'b1;
        #1;
        checks++; if (sq_empty !== 1'b0) begin errors++; $display("FAIL reset_sq_empty_stv got=%b exp=0", sq_empty); end
        st_valid = 1'b0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_basic();
        drive_st(1'b1, 64'hDEAD_BEEF_0000_0001, 32'h1000, 2'b11, 7'd5);
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL basic_no_bypass got=%b exp=0", wb_valid); end
        tick();
        st_valid = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL basic_wb_valid got=%b exp=1", wb_valid); end
        checks++; if (wb_memdata !== 64'hDEAD_BEEF_0000_0001) begin errors++; $display("FAIL basic_data got=%h exp=deadbeef00000001", wb_memdata); end
        checks++; if (wb_memaddr !== 32'h1000) begin errors++; $display("FAIL basic_addr got=%h exp=1000", wb_memaddr); end
        checks++; if (wb_size !== 2'b11) begin errors++; $display("FAIL basic_size got=%b exp=11", wb_size); end
        checks++; if (wb_ptcid !== 7'd5) begin errors++; $display("FAIL basic_ptcid got=%0d exp=5", wb_ptcid); end
        tick();
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL basic_popped got=%b exp=0", wb_valid); end
        checks++; if (sq_empty !== 1'b1) begin errors++; $display("FAIL basic_sq_empty got=%b exp=1", sq_empty); end
    endtask

    task automatic test_full();
        pulse_clr();
        wbaq_isfull = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_st(1'b1, 64'h1000 + 64'(i), 32'h5000 + 32'(8 * i), 2'b11, 7'(i));
            tick();
        end
        #1;
        checks++; if (st_full !== 1'b1) begin errors++; $display("FAIL full_st_full got=%b exp=1", st_full); end
        drive_st(1'b1, 64'h55, 32'h6000, 2'b00, 7'd9);
        tick();
        st_valid = 1'b0;
        wbaq_isfull = 1'b0;
        #1;
        checks++; if (st_full !== 1'b1) begin errors++; $display("FAIL full_drop_st_full got=%b exp=1", st_full); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (wb_memdata !== 64'h1000 + 64'(i)) begin errors++; $display("FAIL full_drain_%0d got=%h exp=%h", i, wb_memdata, 64'h1000 + 64'(i)); end
            tick();
            #1;
        end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL full_dropped_entry got=%b exp=0", wb_valid); end
    endtask

    task automatic test_push_pop();
        pulse_clr();
        wbaq_isfull = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_st(1'b1, 64'hA0 + 64'(i), 32'h7000, 2'b00, 7'd1);
            tick();
        end
        drive_st(1'b1, 64'hAA, 32'h7000, 2'b00, 7'd1);
        wbaq_isfull = 1'b0;
        tick();
        st_valid = 1'b0;
        #1;
        checks++; if (st_full !== 1'b0) begin errors++; $display("FAIL pp_refused_count got=%b exp=0", st_full); end
        checks++; if (wb_memdata !== 64'hA1) begin errors++; $display("FAIL pp_head_a1 got=%h exp=a1", wb_memdata); end
        tick();
        drive_st(1'b1, 64'hBB, 32'h7000, 2'b00, 7'd1);
        tick();
        drive_st(1'b1, 64'hCC, 32'h7000, 2'b00, 7'd1);
        #1;
        checks++; if (wb_memdata !== 64'hA3) begin errors++; $display("FAIL pp_head_a3 got=%h exp=a3", wb_memdata); end
        tick();
        st_valid = 1'b0;
        #1;
        checks++; if (wb_memdata !== 64'hBB) begin errors++; $display("FAIL pp_head_bb got=%h exp=bb", wb_memdata); end
        tick();
        #1;
        checks++; if (wb_memdata !== 64'hCC) begin errors++; $display("FAIL pp_head_cc got=%h exp=cc", wb_memdata); end
        tick();
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL pp_empty got=%b exp=0", wb_valid); end
    endtask

    task automatic test_overlap();
        pulse_clr();
        wbaq_isfull = 1'b1;
        drive_st(1'b1, 64'h1, 32'h2006, 2'b10, 7'd2);
        tick();
        st_valid = 1'b0;
        q1_valid = 1'b1; q1_addr = 32'h2008; q_size = 2'b00;
        #1;
        checks++; if (fwd_stall !== 1'b1) begin errors++; $display("FAIL ovl_2008 got=%b exp=1", fwd_stall); end
        q1_addr = 32'h2010;
        #1;
        checks++; if (fwd_stall !== 1'b0) begin errors++; $display("FAIL ovl_2010 got=%b exp=0", fwd_stall); end
        q1_addr = 32'h1FFF; q_size = 2'b11;
        #1;
        checks++; if (fwd_stall !== 1'b1) begin errors++; $display("FAIL ovl_1fff_8b got=%b exp=1", fwd_stall); end
        q1_addr = 32'h2008; q_size = 2'b00; q1_valid = 1'b0;
        #1;
        checks++; if (fwd_stall !== 1'b0) begin errors++; $display("FAIL ovl_q1_invalid got=%b exp=0", fwd_stall); end
        q1_valid = 1'b1;
        wbaq_isfull = 1'b0;
        tick();
        #1;
        checks++; if (fwd_stall !== 1'b0) begin errors++; $display("FAIL ovl_after_pop got=%b exp=0", fwd_stall); end
        q1_valid = 1'b0;
    endtask

    task automatic test_incoming();
        pulse_clr();
        drive_st(1'b1, 64'h2, 32'h3000, 2'b11, 7'd3);
        q2_valid = 1'b1; q2_addr = 32'h3004; q_size = 2'b10;
        #1;
        checks++; if (fwd_stall !== 1'b1) begin errors++; $display("FAIL inc_stall got=%b exp=1", fwd_stall); end
        checks++; if (sq_empty !== 1'b0) begin errors++; $display("FAIL inc_sq_empty got=%b exp=0", sq_empty); end
        st_valid = 1'b0;
        #1;
        checks++; if (fwd_stall !== 1'b0) begin errors++; $display("FAIL inc_no_store got=%b exp=0", fwd_stall); end
        q2_valid = 1'b0;
    endtask

    task automatic test_async_clr();
        pulse_clr();
        wbaq_isfull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_st(1'b1, 64'h300 + 64'(i), 32'h8000, 2'b01, 7'd4);
            tick();
        end
        st_valid = 1'b0;
        wbaq_isfull = 1'b0;
        #2;
        clr = 1'b1;
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL aclr_wb_valid got=%b exp=0", wb_valid); end
        checks++; if (st_full !== 1'b0) begin errors++; $display("FAIL aclr_st_full got=%b exp=0", st_full); end
        checks++; if (wb_memdata !== 64'd0) begin errors++; $display("FAIL aclr_wb_memdata got=%h exp=0", wb_memdata); end
        tick();
        clr = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL aclr_after got=%b exp=0", wb_valid); end
    endtask

    task automatic test_random();
        ent_t h;
        pulse_clr();
        for (int c = 0; c < 400; c++) begin
            st_valid    = (mdl.size() < DEPTH) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
            st_data     = {$urandom, $urandom};
            st_addr     = 32'h4000 + 32'($urandom_range(0, 47));
            st_size     = 2'($urandom_range(0, 3));
            st_ptcid    = 7'($urandom_range(0, 127));
            wbaq_isfull = ($urandom_range(0, 9) < 4);
            q1_valid    = 1'($urandom_range(0, 1));
            q2_valid    = 1'($urandom_range(0, 1));
            q1_addr     = 32'h4000 + 32'($urandom_range(0, 63));
            q2_addr     = 32'h4000 + 32'($urandom_range(0, 63));
            q_size      = 2'($urandom_range(0, 3));
            #1;
            checks++; if (wb_valid !== (mdl.size() > 0)) begin errors++; $display("FAIL rnd_wb_valid c=%0d got=%b exp=%b", c, wb_valid, mdl.size() > 0); end
            if (mdl.size() > 0) begin
                h = mdl[0];
                checks++; if ({wb_memdata, wb_memaddr, wb_size, wb_ptcid} !== {h.d, h.a, h.s, h.p}) begin
                    errors++; $display("FAIL rnd_head c=%0d got=%h/%h/%b/%0d exp=%h/%h/%b/%0d", c, wb_memdata, wb_memaddr, wb_size, wb_ptcid, h.d, h.a, h.s, h.p);
                end
            end else begin
                checks++; if (wb_memdata !== 64'd0) begin errors++; $display("FAIL rnd_empty_data c=%0d got=%h exp=0", c, wb_memdata); end
            end
            checks++; if (st_full !== (mdl.size() == DEPTH)) begin errors++; $display("FAIL rnd_st_full c=%0d got=%b exp=%b", c, st_full, mdl.size() == DEPTH); end
            checks++; if (sq_empty !== (mdl.size() == 0 && !st_valid)) begin errors++; $display("FAIL rnd_sq_empty c=%0d got=%b", c, sq_empty); end
            checks++; if (fwd_stall !== mdl_stall()) begin errors++; $display("FAIL rnd_fwd_stall c=%0d got=%b exp=%b", c, fwd_stall, mdl_stall()); end
            tick();
        end
        st_valid = 1'b0; q1_valid = 1'b0; q2_valid = 1'b0; wbaq_isfull = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_push_pop();
        test_overlap();
        test_incoming();
        test_async_clr();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_store_queue.md
# wb_store_queue

Write-back store queue between the writeback stage and the memory stage. Buffers committed memory writes (data, address, size, PTC id) in a small FIFO and drains them into the data cache's write-back address queue under its full back-pressure. Compares in-flight memory-stage read addresses against all pending stores and drives the memory stage's `fwd_stall` so no load passes an older store to the same quadword.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2
- CNT_W, $clog2(DEPTH)+1: occupancy counter width
- clk  in  1  stage clock; all state on posedge
- clr  in  1  asynchronous active-high reset
- st_valid  in  1  writeback presents a committed store this cycle
- st_data  in  64  store data, right-justified
- st_addr  in  32  store byte address
- st_size  in  2  00=1B, 01=2B, 10=4B, 11=8B
- st_ptcid  in  7  PTC id of the storing instruction
- st_full  out  1  queue full; writeback must hold `st_valid` low
- wb_valid  out  1  head entry valid, to memory stage
- wb_memdata  out  64  head data
- wb_memaddr  out  32  head address
- wb_size  out  2  head size
- wb_ptcid  out  7  head PTC id
- wbaq_isfull  in  1  cache write-back queue full; head not taken
- q1_valid, q2_valid  in  1 each  memory-stage read operand 1/2 is a real access
- q1_addr, q2_addr  in  32 each  read byte addresses (q2 = post-push stack address)
- q_size  in  2  read size, same encoding as `st_size`
- fwd_stall  out  1  read conflicts with a pending or incoming store
- sq_empty  out  1  no pending stores (serialisation point for IDTR/fault entry)

## Operation
- Storage: DEPTH entries {data, addr, size, ptcid, v}; head/tail pointers (log2 DEPTH bits, wrap naturally), count CNT_W bits.
- Push: `st_valid & ~st_full` writes entry at tail, tail+1, count+1. `st_valid` while full is a protocol error; entry dropped, state unchanged.
- Pop: `wb_valid & ~wbaq_isfull` clears head v, head+1, count−1.
- Push and pop in the same cycle: both take effect, count unchanged. At full, push is refused (st_full sampled from current count) even if pop occurs.
- No bypass: a store pushed into an empty queue appears on `wb_*` the next cycle.
- `wb_*` drive the head entry combinationally; `wb_valid = (count != 0)`; when empty, data/addr/size/ptcid outputs are 0.
- Overlap: each store spans quadwords QS = addr[31:3] and QE = (addr + bytes − 1)[31:3] (32-bit add, wrap at 2^32 ignored, carry discarded). A read likewise spans RS/RE. Conflict when any of QS, QE equals any of RS, RE (conservative, quadword granularity).
- `fwd_stall` = OR over valid entries and over the incoming store (`st_valid`) of conflict with q1 (if q1_valid) or q2 (if q2_valid). Combinational; no registered delay.
- `sq_empty = (count == 0) & ~st_valid`.
- `st_full = (count == DEPTH)`.

## Timing
- Reset (async, clr=1): head=tail=count=0, all v=0 → wb_valid=0, wb_* data=0, st_full=0, fwd_stall=0 unless st_valid/q inputs raise it, sq_empty=~st_valid.
- clr released mid-stream: all pending stores lost; writeback is also reset by clr.
- Store latency: push cycle N → `wb_valid` cycle N+1 → leaves on first cycle with `wbaq_isfull=0`.
- Stall held indefinitely while `wbaq_isfull=1`; head entry and its outputs stable.
- `fwd_stall` drops the cycle after the last conflicting entry pops.

## Structure
- Shared package: size encodings, `SZ_BYTES` lookup (1/2/4/8), quadword shift constant (3), store-entry field widths (64/32/2/7).
- One sub-module `wsq_overlap`: given store addr/size and read addr/size, computes both end-quadwords with kogeAdder and returns the 4-way equality conflict bit; instantiated DEPTH+1 times per read port.

## Test plan
- Reset then push {addr=0x1000, size=11, data=0xDEAD_BEEF_0000_0001, ptcid=5}, wbaq_isfull=0 → wb_valid=1 next cycle with same fields, popped that cycle, sq_empty=1 after.
- Push 4 stores with wbaq_isfull=1 → st_full=1 after 4th; 5th st_valid dropped; release wbaq_isfull → drains in push order, one per cycle.
- At count=4 assert push and pop together → push refused, count=3; at count=2 push+pop → count stays 2, order preserved across pointer wrap.
- Pending store addr=0x2006 size=10 (spans 0x2000 and 0x2008 quadwords); q1_addr=0x2008 q_size=00 q1_valid=1 → fwd_stall=1; q1_addr=0x2010 → 0; q1_valid=0 → 0.
- Empty queue, st_valid=1 addr=0x3000 with q2_addr=0x3004 q2_valid=1 → fwd_stall=1 and sq_empty=0 same cycle.
- clr asserted with 3 entries pending, asynchronously mid-cycle → wb_valid=0 and st_full=0 immediately, no pop occurs.
